// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit: stage levels,
// FSM states and the level-to-thermometer helper.
package pipe_ctrl_pkg;

  localparam int unsigned StallWDefault = 6;

  // Stall levels: a request at level L stalls bus bits 0..L.
  localparam logic [3:0] LvlPc  = 4'd0;
  localparam logic [3:0] LvlIf  = 4'd1;
  localparam logic [3:0] LvlId  = 4'd2;
  localparam logic [3:0] LvlEx  = 4'd3;
  localparam logic [3:0] LvlMem = 4'd4;
  localparam logic [3:0] LvlWb  = 4'd5;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } state_e;

  // Level L -> mask with bits 0..L set.
  function automatic logic [31:0] lvl_to_therm(input logic [3:0] lvl);
    logic [31:0] one_hot;
    one_hot = 32'd1 << (32'(lvl) + 32'd1);
    return one_hot - 32'd1;
  endfunction

endpackage

// File: rtl/stall_merge.sv
// Combinational stall merge: picks the deepest active request level and
// expands it into the per-stage thermometer stall vector.
module stall_merge
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned         STALL_W = StallWDefault,
  parameter int unsigned         NREQ    = 2,
  parameter logic [NREQ*4-1:0]   REQ_LVL = {LvlEx, LvlId}
) (
  input  logic [NREQ-1:0]    stallreq,
  output logic [STALL_W-1:0] stall
);

  logic        any_req;
  logic [3:0]  max_lvl;
  logic [31:0] therm;

  always_comb begin
    any_req = 1'b0;
    max_lvl = 4'd0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (stallreq[i]) begin
        any_req = 1'b1;
        if (REQ_LVL[i*4 +: 4] > max_lvl) begin
          max_lvl = REQ_LVL[i*4 +: 4];
        end
      end
    end
    therm = lvl_to_therm(max_lvl);
    stall = any_req ? therm[STALL_W-1:0] : '0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences exception flushes
// with a registered redirect PC, and tracks stall statistics plus a watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       STALL_W   = StallWDefault,
  parameter int unsigned       NREQ      = 2,
  parameter logic [NREQ*4-1:0] REQ_LVL   = {LvlEx, LvlId},
  parameter int unsigned       FLUSH_CYC = 1,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    stallreq,
  input  logic               excp_req,
  input  logic [31:0]        excp_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic [31:0]        stall_cnt,
  output logic               stall_timeout
);

  localparam logic [31:0] FlushLoad  = 32'(FLUSH_CYC - 1);
  localparam logic [31:0] TimeoutEnd = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_q, timeout_d;

  logic [STALL_W-1:0] merged;
  logic               stalled;

  stall_merge #(
    .STALL_W (STALL_W),
    .NREQ    (NREQ),
    .REQ_LVL (REQ_LVL)
  ) u_stall_merge (
    .stallreq (stallreq),
    .stall    (merged)
  );

  // Flushed instructions are dead, so their stall requests are dropped.
  assign stall         = (rst || state_q == StFlush) ? '0 : merged;
  assign stalled       = (stall != '0);
  assign flush         = (state_q == StFlush);
  assign new_pc        = new_pc_q;
  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = timeout_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;

    unique case (state_q)
      StRun: begin
        if (excp_req) begin
          state_d     = StFlush;
          new_pc_d    = excp_pc;
          flush_cnt_d = FlushLoad;
        end
      end
      StFlush: begin
        if (excp_req) begin
          // Later exception wins and restarts the flush window.
          new_pc_d    = excp_pc;
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q == 32'd0) begin
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 32'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_cnt_d   = 32'd0;
    timeout_d   = timeout_q;

    if (stalled && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    if (stalled && !flush) begin
      run_cnt_d = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
      if (run_cnt_q == TimeoutEnd) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= 32'd0;
      new_pc_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
      run_cnt_q   <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with single-cycle flush and a short
// watchdog, a second with a three-cycle flush window for back-to-back exceptions.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stallreq;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        stall_timeout;

  logic [1:0]  stallreq_b;
  logic        excp_req_b;
  logic [31:0] excp_pc_b;
  logic [5:0]  stall_b;
  logic        flush_b;
  logic [31:0] new_pc_b;
  logic [31:0] stall_cnt_b;
  logic        stall_timeout_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FLUSH_CYC (1),
    .TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq      (stallreq),
    .excp_req      (excp_req),
    .excp_pc       (excp_pc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  pipe_ctrl #(
    .FLUSH_CYC (3)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .stallreq      (stallreq_b),
    .excp_req      (excp_req_b),
    .excp_pc       (excp_pc_b),
    .stall         (stall_b),
    .flush         (flush_b),
    .new_pc        (new_pc_b),
    .stall_cnt     (stall_cnt_b),
    .stall_timeout (stall_timeout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    stallreq   = 2'b00;
    excp_req   = 1'b0;
    excp_pc    = 32'h0;
    stallreq_b = 2'b00;
    excp_req_b = 1'b0;
    excp_pc_b  = 32'h0;

    // Reset / idle
    tick();
    stallreq = 2'b10;
    #1 check("stall_in_rst", 32'(stall), 32'h0);
    tick();
    stallreq = 2'b00;
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);

    // Merge
    stallreq = 2'b01;
    #1 check("merge_id", 32'(stall), 32'h07);
    tick();
    stallreq = 2'b10;
    #1 check("merge_ex", 32'(stall), 32'h0F);
    tick();
    stallreq = 2'b11;
    #1 check("merge_both", 32'(stall), 32'h0F);
    tick();
    stallreq = 2'b00;
    #1;
    check("merge_cnt", stall_cnt, 32'd3);
    check("merge_idle", 32'(stall), 32'h0);
    tick();

    // Flush with simultaneous stall
    stallreq = 2'b10;
    excp_req = 1'b1;
    excp_pc  = 32'hBFC0_0380;
    #1 check("fl_n_stall", 32'(stall), 32'h0F);
    tick();
    excp_req = 1'b0;
    excp_pc  = 32'h0;
    #1;
    check("fl_n1_flush", 32'(flush), 32'h1);
    check("fl_n1_pc", new_pc, 32'hBFC0_0380);
    check("fl_n1_stall", 32'(stall), 32'h0);
    tick();
    #1;
    check("fl_n2_flush", 32'(flush), 32'h0);
    check("fl_n2_stall", 32'(stall), 32'h0F);
    stallreq = 2'b00;
    #1 check("fl_cnt", stall_cnt, 32'd4);
    tick();

    // Watchdog: 7-cycle run then idle must not fire
    stallreq = 2'b01;
    repeat (7) tick();
    stallreq = 2'b00;
    tick();
    check("wd_run7", 32'(stall_timeout), 32'h0);
    stallreq = 2'b01;
    repeat (7) tick();
    check("wd_run8_early", 32'(stall_timeout), 32'h0);
    tick();
    check("wd_run8_fire", 32'(stall_timeout), 32'h1);
    stallreq = 2'b00;
    tick();
    check("wd_sticky", 32'(stall_timeout), 32'h1);
    check("wd_cnt", stall_cnt, 32'd19);

    // Saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    stallreq = 2'b01;
    tick();
    check("sat_1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    check("sat_3", stall_cnt, 32'hFFFF_FFFF);
    stallreq = 2'b00;

    // Reset in the middle of a flush
    excp_req = 1'b1;
    excp_pc  = 32'h0000_1234;
    tick();
    excp_req = 1'b0;
    check("mr_flush_on", 32'(flush), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_flush", 32'(flush), 32'h0);
    check("mr_pc", new_pc, 32'h0);
    check("mr_timeout", 32'(stall_timeout), 32'h0);
    check("mr_cnt", stall_cnt, 32'h0);

    // Back-to-back exceptions, FLUSH_CYC = 3
    excp_req_b = 1'b1;
    excp_pc_b  = 32'hAAAA_0000;
    tick();
    excp_pc_b  = 32'hBBBB_0000;
    check("bb_n1_flush", 32'(flush_b), 32'h1);
    check("bb_n1_pc", new_pc_b, 32'hAAAA_0000);
    tick();
    excp_req_b = 1'b0;
    check("bb_n2_flush", 32'(flush_b), 32'h1);
    check("bb_n2_pc", new_pc_b, 32'hBBBB_0000);
    tick();
    check("bb_n3_flush", 32'(flush_b), 32'h1);
    tick();
    check("bb_n4_flush", 32'(flush_b), 32'h1);
    check("bb_n4_pc", new_pc_b, 32'hBBBB_0000);
    tick();
    check("bb_n5_flush", 32'(flush_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the five-stage CPU core: it merges N stall requests from the pipeline stages into the per-stage stall bus and sequences exception flushes with a registered redirect PC. It also keeps a stall-cycle performance counter and a stall watchdog. It sits beside the datapath, driving stall/flush to every pipeline register and the PC stage.

## Interface

Parameters:
- STALL_W, 6: stall bus width; bit 0 = PC, bit i = pipeline register i.
- NREQ, 2: number of stall request sources.
- REQ_LVL, {4'd3, 4'd2}: packed NREQ×4-bit field; request i stalls bits 0..REQ_LVL[i]. Default: req1 (ex) → level 3, req0 (id) → level 2. Every entry must be < STALL_W.
- FLUSH_CYC, 1: cycles flush stays asserted per exception, ≥1.
- TIMEOUT, 1024: consecutive stalled cycles before the watchdog fires.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stallreq  in  NREQ  per-source stall request, level-sensitive.
- excp_req  in  1  exception/redirect request, sampled on posedge.
- excp_pc  in  32  redirect target, valid with excp_req.
- stall  out  STALL_W  per-stage stall vector.
- flush  out  1  flush all pipeline registers.
- new_pc  out  32  redirect PC, valid while flush=1.
- stall_cnt  out  32  saturating count of cycles with stall≠0.
- stall_timeout  out  1  sticky watchdog flag.

## Operation

- Stall merge: L = max REQ_LVL[i] over all active stallreq[i]. Then stall = (1<<(L+1))−1, or 0 when no request is active. With the defaults, ex gives 6'b001111, id gives 6'b000111, and both give 6'b001111.
- FSM states are RUN and FLUSH.
  - RUN: stall is the merged value. When excp_req=1 at a posedge, the block latches new_pc←excp_pc, loads flush_cnt←FLUSH_CYC−1, and goes to FLUSH.
  - FLUSH: flush=1 and stall is forced to 0. Stall requests are ignored because the flushed instructions are dead.
    - If flush_cnt=0 and there is no new excp_req: return to RUN.
    - Otherwise flush_cnt decrements.
  - excp_req arriving during FLUSH: re-latch new_pc, reload flush_cnt←FLUSH_CYC−1, stay in FLUSH. The later exception wins.
- Exception and stall in the same RUN cycle: stall applies in that cycle, and the flush follows on the next cycle.
- stall_cnt increments every cycle where stall≠0 and saturates at 32'hFFFF_FFFF. There is no wrap.
- Watchdog:
  - run_cnt increments on each consecutive cycle with stall≠0 and clears when stall=0 or flush=1.
  - When run_cnt reaches TIMEOUT−1 while still stalled, stall_timeout is set on the next edge.
  - stall_timeout stays set until rst.

## Timing

- stall is combinational from stallreq and state, with zero-cycle latency. There are no register stages on the request→stall path.
- flush and new_pc are registered. excp_req sampled at edge n gives flush=1 for cycles n+1 … n+FLUSH_CYC.
- Reset values (the cycle after rst is high at a posedge):
  - state = RUN
  - stall = 0 (forced to 0 combinationally whenever rst=1)
  - flush = 0
  - new_pc = 32'h0
  - stall_cnt = 0
  - run_cnt = 0
  - stall_timeout = 0
- rst takes priority over everything. Reset during FLUSH aborts the flush immediately.
- stall_timeout asserts TIMEOUT cycles after the first stalled cycle of an unbroken stall run.

## Structure

- STALL_W default, the stall-level encodings (PC, IF, ID, EX, MEM, WB) and the FSM state encodings belong in lib/defines.vh.
- The max-level merge and the one-hot-to-thermometer expansion are a natural combinational submodule, stall_merge. It is parametrised by NREQ, STALL_W and REQ_LVL.
- Counters and the FSM stay in pipe_ctrl.

## Test plan

- Reset/idle: rst=1 for 2 cycles, then stallreq=0 → stall=0, flush=0, new_pc=0, stall_cnt=0.
- Merge: stallreq=2'b01 → stall=6'b000111 in the same cycle; 2'b10 → 6'b001111; 2'b11 → 6'b001111. After 3 such cycles, stall_cnt=3.
- Flush:
  - excp_req=1 with excp_pc=32'hBFC0_0380 at edge n, while stallreq=2'b10 held → stall=6'b001111 in cycle n.
  - Cycle n+1: flush=1, new_pc=32'hBFC0_0380, stall=0.
  - Cycle n+2: flush=0 and stall=6'b001111 again.
- Back-to-back exceptions: FLUSH_CYC=3; excp_pc=A at edge n, then B at edge n+1 → flush=1 for cycles n+1…n+4, and new_pc=B from cycle n+2.
- Watchdog: TIMEOUT=8, stallreq=2'b01 held → stall_timeout rises after 8 stalled cycles and stays set after stallreq drops. A 7-cycle run separated by one idle cycle must not fire.
- Saturation and mid-flush reset:
  - Force stall_cnt to 32'hFFFF_FFFE and stall 3 cycles → stall_cnt holds at 32'hFFFF_FFFF.
  - Assert rst during FLUSH → flush=0 and new_pc=0 on the next cycle.
